bootmem: RTL

Byte-wide unified instruction/data memory that serves as the responder for the multicycle MIPS core's memory interface (memread, memwrite, adr, writedata, memdata). After reset it first fills itself from an external byte-stream loader through a valid/ready handshake, holding the core in reset. When loading completes it releases the core and serves its fetches, loads and stores. An optional memory-mapped output port gives programs a visible result channel.

---
 rtl/bootmem.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bootmem.sv
// ---------------------------------------------------------------------------
// bootmem -- byte-wide unified instruction/data memory for the multicycle
// MIPS core, with a built-in boot loader front end.
//
// After reset the block fills its array from an external byte stream
// (valid/ready handshake) while holding the core in reset. Once the stream
// ends (ld_last, or the top address has been written) it spends one cycle in
// RELEASE, then drops cpu_reset and serves the core's reads and writes.
//
// Optional feature macro: BOOTMEM_OUTPORT_EN
//   When defined, address all-ones in RUN is a memory-mapped output port:
//   stores there update out_port and pulse out_strobe instead of writing
//   the array, and loads there return out_port.
//   When undefined, all-ones is ordinary memory and out_port/out_strobe
//   are constant 0.
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   reset       in   asynchronous active-low reset
//   ld_valid    in   loader byte valid
//   ld_data     in   loader byte
//   ld_last     in   final loader byte marker (qualified by ld_valid)
//   ld_ready    out  loader byte accepted this cycle when ld_valid is high
//   cpu_reset   out  registered active-high synchronous reset for the core
//   memread     in   core read request
//   memwrite    in   core write request
//   adr         in   core byte address
//   writedata   in   core store data (low byte is stored)
//   memdata     out  combinational read data to the core
//   out_port    out  last value stored to the output port
//   out_strobe  out  one-cycle pulse after each output-port store
// ---------------------------------------------------------------------------
module bootmem #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    input  logic [7:0]       ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             cpu_reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic [7:0]       out_port,
    output logic             out_strobe
);

    localparam int               DEPTH   = 1 << WIDTH;
    localparam logic [WIDTH-1:0] ADR_TOP = '1;

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] ptr_q;
    logic             cpu_reset_q;

    // Memory array: deliberately not reset, so a reload only overwrites the
    // bytes it actually delivers.
    logic [7:0]       mem_q [DEPTH];

    logic             run;
    logic             ld_hs;
    logic             port_hit;
    logic             mem_we_d;
    logic [WIDTH-1:0] mem_waddr_d;
    logic [7:0]       mem_wdata_d;
    logic [7:0]       rd_byte;

    assign run = (state_q == S_RUN);

    // ld_ready is gated by reset itself so it reads 0 while reset is held,
    // not just from the first edge after it is applied.
    assign ld_ready = reset && (state_q == S_LOAD);
    assign ld_hs    = ld_valid && ld_ready;

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_LOAD;
            ptr_q       <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            // cpu_reset follows the state one edge late: it stays high
            // through the RELEASE cycle and falls on the first edge seen in
            // RUN, giving the core a clean reset cycle after the last byte.
            cpu_reset_q <= (state_q != S_RUN);
            case (state_q)
                S_LOAD: begin
                    if (ld_hs) begin
                        ptr_q <= ptr_q + 1'b1;
                        // Writing the top address ends the load even without
                        // ld_last; the pointer wraps harmlessly to 0.
                        if (ld_last || (ptr_q == ADR_TOP)) begin
                            state_q <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: state_q <= S_RUN;
                S_RUN:     state_q <= S_RUN;
                default:   state_q <= S_LOAD;
            endcase
        end
    end

    assign cpu_reset = cpu_reset_q;

    // -----------------------------------------------------------------------
    // Output port decode
    // -----------------------------------------------------------------------
`ifdef BOOTMEM_OUTPORT_EN
    logic [7:0] out_port_q;
    logic       out_strobe_q;

    // Only the core sees the port; loader writes to all-ones hit the array.
    assign port_hit = run && (adr == ADR_TOP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_port_q   <= 8'h00;
            out_strobe_q <= 1'b0;
        end else begin
            out_strobe_q <= port_hit && memwrite;
            if (port_hit && memwrite) begin
                out_port_q <= writedata[7:0];
            end
        end
    end

    assign out_port   = out_port_q;
    assign out_strobe = out_strobe_q;
`else
    assign port_hit   = 1'b0;
    assign out_port   = 8'h00;
    assign out_strobe = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Single write port, shared between loader and core by state
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = ptr_q;
        mem_wdata_d = ld_data;
        if (state_q == S_LOAD) begin
            mem_we_d = ld_hs;
        end else if (run) begin
            mem_we_d    = memwrite && !port_hit;
            mem_waddr_d = adr;
            mem_wdata_d = writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Combinational read: the core's FETCH/LBRD states capture memdata at
    // the end of the same cycle. A read to an address being written this
    // cycle naturally returns the old byte, since the array updates on the
    // edge.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_byte = mem_q[adr];
        if (port_hit) begin
            rd_byte = out_port;
        end
    end

    assign memdata = (run && memread) ? WIDTH'(rd_byte) : '0;

endmodule
